// File: rtl/spio_hss_multiplexer_ctr_bank_if.sv
// Register access bus shared by the HSS multiplexer register banks.
// Master drives strobes/address/data; slave returns combinational read data.
`timescale 1ns/1ps
interface spio_hss_multiplexer_ctr_bank_if #(
    parameter int REGA_BITS = 5,
    parameter int REGD_BITS = 32
);
    logic                 reg_write;
    logic                 reg_read;
    logic [REGA_BITS-1:0] reg_addr;
    logic [REGD_BITS-1:0] reg_write_data;
    logic [REGD_BITS-1:0] reg_read_data;

    modport master (
        output reg_write,
        output reg_read,
        output reg_addr,
        output reg_write_data,
        input  reg_read_data
    );

    modport slave (
        input  reg_write,
        input  reg_read,
        input  reg_addr,
        input  reg_write_data,
        output reg_read_data
    );
endinterface

// File: rtl/spio_hss_multiplexer_ctr_bank.sv
// Event-counter bank for the HSS multiplexer: wrap/saturate, sticky
// overflow, clear-on-read, freeze and preload through the register bus.
`timescale 1ns/1ps
module spio_hss_multiplexer_ctr_bank #(
    parameter int NUM_CTRS  = 16,
    parameter int CTR_BITS  = 32,
    parameter int REGD_BITS = 32,
    parameter int REGA_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CTRS-1:0] ctr_evt,
    spio_hss_multiplexer_ctr_bank_if.slave bus,
    output logic [NUM_CTRS-1:0] ctr_ovfl
);

    localparam logic [REGA_BITS-1:0] A_CTRL = REGA_BITS'(NUM_CTRS);
    localparam logic [REGA_BITS-1:0] A_OVFL = REGA_BITS'(NUM_CTRS + 1);
    localparam logic [CTR_BITS-1:0]  C_MAX  = '1;

    logic [CTR_BITS-1:0] cnt_q [NUM_CTRS];
    logic [CTR_BITS-1:0] cnt_d [NUM_CTRS];
    logic [2:0]          ctrl_q, ctrl_d;
    logic [NUM_CTRS-1:0] ovfl_q, ovfl_d;
    logic [NUM_CTRS-1:0] ovfl_set;
    logic [NUM_CTRS-1:0] ovfl_clr;

    logic sat, cor, frz;
    logic wr_ctrl, wr_ovfl;

    assign sat     = ctrl_q[0];
    assign cor     = ctrl_q[1];
    assign frz     = ctrl_q[2];
    assign wr_ctrl = bus.reg_write && (bus.reg_addr == A_CTRL);
    assign wr_ovfl = bus.reg_write && (bus.reg_addr == A_OVFL);

    // Per-counter next state: load, then clearing read, then event, else hold.
    always_comb begin
        ovfl_set = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            logic hit;
            logic evt_ok;
            hit      = (bus.reg_addr == REGA_BITS'(i));
            evt_ok   = ctr_evt[i] && !frz;
            cnt_d[i] = cnt_q[i];
            if (bus.reg_write && hit) begin
                cnt_d[i] = bus.reg_write_data[CTR_BITS-1:0];
            end else if (cor && bus.reg_read && hit) begin
                cnt_d[i] = evt_ok ? CTR_BITS'(1) : '0;
            end else if (evt_ok) begin
                if (cnt_q[i] != C_MAX) begin
                    cnt_d[i] = cnt_q[i] + CTR_BITS'(1);
                end else begin
                    ovfl_set[i] = 1'b1;
                    cnt_d[i]    = sat ? C_MAX : '0;
                end
            end
        end
    end

    // Control and sticky overflow next state; a same-cycle set beats W1C.
    always_comb begin
        ctrl_d   = wr_ctrl ? bus.reg_write_data[2:0] : ctrl_q;
        ovfl_clr = wr_ovfl ? bus.reg_write_data[NUM_CTRS-1:0] : '0;
        ovfl_d   = ovfl_set | (ovfl_q & ~ovfl_clr);
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                cnt_q[i] <= '0;
            end
            ctrl_q <= '0;
            ovfl_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ctrl_q <= ctrl_d;
            ovfl_q <= ovfl_d;
        end
    end

    // Zero-latency read mux; unmapped addresses read all ones.
    always_comb begin
        bus.reg_read_data = '1;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (bus.reg_addr == REGA_BITS'(i)) begin
                bus.reg_read_data = REGD_BITS'(cnt_q[i]);
            end
        end
        if (bus.reg_addr == A_CTRL) begin
            bus.reg_read_data = REGD_BITS'(ctrl_q);
        end
        if (bus.reg_addr == A_OVFL) begin
            bus.reg_read_data = REGD_BITS'(ovfl_q);
        end
    end

    assign ctr_ovfl = ovfl_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_ctr_bank.sv
// Scoreboard bench: a 16x32 bank and a 4x4 bank for wrap/saturate cases.
// Stimulus pushes expected values; a monitor pops them on each sample strobe.
`timescale 1ns/1ps
module tb_spio_hss_multiplexer_ctr_bank;

    localparam int NA = 16;
    localparam int CA = 32;
    localparam int AA = 5;
    localparam int NB = 4;
    localparam int CB = 4;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          smp = 1'b0;
    logic [NA-1:0] evt_a;
    logic [NA-1:0] ovfl_a;
    logic [NB-1:0] evt_b;
    logic [NB-1:0] ovfl_b;

    always #5 clk = ~clk;

    spio_hss_multiplexer_ctr_bank_if #(.REGA_BITS(AA), .REGD_BITS(32)) busa ();
    spio_hss_multiplexer_ctr_bank_if #(.REGA_BITS(AB), .REGD_BITS(32)) busb ();

    spio_hss_multiplexer_ctr_bank #(
        .NUM_CTRS(NA), .CTR_BITS(CA), .REGD_BITS(32), .REGA_BITS(AA)
    ) dut_a (
        .clk(clk), .rst(rst), .ctr_evt(evt_a),
        .bus(busa.slave), .ctr_ovfl(ovfl_a)
    );

    spio_hss_multiplexer_ctr_bank #(
        .NUM_CTRS(NB), .CTR_BITS(CB), .REGD_BITS(32), .REGA_BITS(AB)
    ) dut_b (
        .clk(clk), .rst(rst), .ctr_evt(evt_b),
        .bus(busb.slave), .ctr_ovfl(ovfl_b)
    );

    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t  eq[$];
    string tq[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    exp_t        m_e;
    string       m_t;
    logic [31:0] m_act;

    always @(posedge smp) begin
        if (eq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: sample with no expectation");
        end else begin
            m_e = eq.pop_front();
            m_t = tq.pop_front();
            if (m_e.kind == 0)
                m_act = (m_e.dut == 0) ? busa.reg_read_data : busb.reg_read_data;
            else
                m_act = (m_e.dut == 0) ? {16'h0, ovfl_a} : {28'h0, ovfl_b};
            n_chk++;
            if (m_act !== m_e.exp) begin
                n_fail++;
                $display("FAIL %0s: got %h expected %h", m_t, m_act, m_e.exp);
            end
        end
    end

    task automatic set_bus(input int d, input logic w, input logic r,
                           input int addr, input logic [31:0] data);
        if (d == 0) begin
            busa.reg_write      = w;
            busa.reg_read       = r;
            busa.reg_addr       = addr[AA-1:0];
            busa.reg_write_data = data;
        end else begin
            busb.reg_write      = w;
            busb.reg_read       = r;
            busb.reg_addr       = addr[AB-1:0];
            busb.reg_write_data = data;
        end
    endtask

    task automatic push_sample(input int d, input int kind,
                               input logic [31:0] exp, input string tag);
        exp_t e;
        e.dut  = d;
        e.kind = kind;
        e.exp  = exp;
        eq.push_back(e);
        tq.push_back(tag);
        #1 smp = 1'b1;
        #1 smp = 1'b0;
    endtask

    task automatic expect_rd(input int d, input int addr,
                             input logic [31:0] exp, input string tag);
        set_bus(d, 1'b0, 1'b0, addr, 32'h0);
        push_sample(d, 0, exp, tag);
    endtask

    task automatic expect_ovfl(input int d, input logic [31:0] exp,
                               input string tag);
        push_sample(d, 1, exp, tag);
    endtask

    task automatic drive(input int d, input logic w, input logic r,
                         input int addr, input logic [31:0] data,
                         input logic [NA-1:0] ea, input logic [NB-1:0] eb,
                         input logic chk, input logic [31:0] exp,
                         input string tag);
        @(negedge clk);
        set_bus(d, w, r, addr, data);
        evt_a = ea;
        evt_b = eb;
        if (chk) push_sample(d, 0, exp, tag);
        @(posedge clk);
        #1;
        set_bus(d, 1'b0, 1'b0, addr, 32'h0);
        evt_a = '0;
        evt_b = '0;
    endtask

    task automatic wr(input int d, input int addr, input logic [31:0] data);
        drive(d, 1'b1, 1'b0, addr, data, '0, '0, 1'b0, 32'h0, "");
    endtask

    task automatic ev(input logic [NA-1:0] ea, input logic [NB-1:0] eb);
        drive(0, 1'b0, 1'b0, 0, 32'h0, ea, eb, 1'b0, 32'h0, "");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        evt_a = '0;
        evt_b = '0;
        set_bus(0, 1'b0, 1'b0, 0, 32'h0);
        set_bus(1, 1'b0, 1'b0, 0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        expect_rd(0, 0, 32'h0, "in_rst_a0");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NA + 2; i++) expect_rd(0, i, 32'h0, "rst_a");
        expect_rd(0, NA + 2, 32'hFFFF_FFFF, "unmapped_a18");
        expect_rd(0, 31, 32'hFFFF_FFFF, "unmapped_a31");
        expect_ovfl(0, 32'h0, "rst_ovfl_a");
        for (int i = 0; i < NB + 2; i++) expect_rd(1, i, 32'h0, "rst_b");
        expect_rd(1, NB + 2, 32'hFFFF_FFFF, "unmapped_b6");
        expect_rd(1, 7, 32'hFFFF_FFFF, "unmapped_b7");
        expect_ovfl(1, 32'h0, "rst_ovfl_b");

        repeat (5) begin
            ev(16'h0008, '0);
            ev('0, '0);
        end
        repeat (10) ev(16'h0001, '0);
        for (int i = 0; i < NA; i++)
            expect_rd(0, i, (i == 3) ? 32'd5 : (i == 0) ? 32'd10 : 32'd0,
                      "basic_cnt");
        expect_ovfl(0, 32'h0, "basic_ovfl");

        wr(1, 1, 32'd15);
        expect_rd(1, 1, 32'd15, "preload_b1");
        ev('0, 4'b0010);
        expect_rd(1, 1, 32'd0, "wrap_b1");
        expect_ovfl(1, 32'h2, "wrap_ovfl");
        wr(1, 5, 32'h2);
        expect_ovfl(1, 32'h0, "w1c_ovfl");
        wr(1, 4, 32'h1);
        expect_rd(1, 4, 32'h1, "ctrl_sat");
        wr(1, 1, 32'd15);
        ev('0, 4'b0010);
        expect_rd(1, 1, 32'd15, "sat_b1");
        expect_ovfl(1, 32'h2, "sat_ovfl");
        drive(1, 1'b1, 1'b0, 5, 32'h2, '0, 4'b0010, 1'b0, 32'h0, "");
        expect_ovfl(1, 32'h2, "set_beats_w1c");
        wr(1, 5, 32'h2);
        expect_ovfl(1, 32'h0, "w1c_ovfl2");
        wr(1, 6, 32'h5);
        expect_rd(1, 6, 32'hFFFF_FFFF, "unmapped_wr");
        expect_rd(1, 0, 32'h0, "unmapped_wr_c0");
        wr(1, 4, 32'hFF);
        expect_rd(1, 4, 32'h7, "ctrl_mask");
        wr(1, 4, 32'h4);
        ev('0, 4'b0010);
        expect_rd(1, 1, 32'd15, "frz_b1");
        expect_ovfl(1, 32'h0, "frz_no_ovfl");
        wr(1, 4, 32'h0);
        ev('0, 4'b0010);
        expect_rd(1, 1, 32'd0, "unfrz_wrap");
        expect_ovfl(1, 32'h2, "unfrz_ovfl");
        wr(1, 0, 32'd15);
        expect_rd(1, 0, 32'd15, "preload_b0");

        wr(0, 16, 32'h2);
        wr(0, 2, 32'd7);
        expect_rd(0, 2, 32'd7, "preload_a2");
        drive(0, 1'b0, 1'b1, 2, 32'h0, 16'h0004, '0, 1'b1, 32'd7, "cor_race_rd");
        expect_rd(0, 2, 32'd1, "cor_race_cnt");
        drive(0, 1'b0, 1'b1, 2, 32'h0, '0, '0, 1'b1, 32'd1, "cor_rd");
        expect_rd(0, 2, 32'd0, "cor_clr");
        drive(0, 1'b0, 1'b1, 16, 32'h0, '0, '0, 1'b1, 32'h2, "cor_ctrl_rd");
        expect_rd(0, 16, 32'h2, "cor_ctrl_kept");
        drive(0, 1'b1, 1'b1, 2, 32'd9, '0, '0, 1'b1, 32'd0, "wr_rd_same");
        expect_rd(0, 2, 32'd9, "wr_beats_cor");
        wr(0, 16, 32'h0);

        wr(0, 16, 32'h4);
        repeat (4) ev(16'h0020, '0);
        expect_rd(0, 5, 32'h0, "frz_c5");
        ev('1, '0);
        expect_rd(0, 0, 32'd10, "frz_c0");
        drive(0, 1'b1, 1'b0, 5, 32'h1234, 16'h0020, '0, 1'b0, 32'h0, "");
        expect_rd(0, 5, 32'h1234, "frz_load");
        drive(0, 1'b1, 1'b0, 16, 32'h0, 16'h0020, '0, 1'b0, 32'h0, "");
        expect_rd(0, 5, 32'h1234, "mode_delay");
        ev(16'h0020, '0);
        expect_rd(0, 5, 32'h1235, "unfrz_inc");

        @(negedge clk);
        evt_a = '1;
        evt_b = '1;
        @(posedge clk);
        @(posedge clk);
        #2;
        expect_ovfl(1, 32'h3, "pre_rst_ovfl_b");
        expect_rd(0, 0, 32'd12, "pre_rst_a0");
        rst = 1'b1;
        #1;
        expect_rd(0, 0, 32'h0, "arst_a0");
        expect_ovfl(1, 32'h0, "arst_ovfl_b");
        expect_rd(0, 5, 32'h0, "arst_a5");
        expect_rd(1, 0, 32'h0, "arst_b0");
        expect_ovfl(0, 32'h0, "arst_ovfl_a");
        repeat (3) @(posedge clk);
        #1;
        expect_rd(0, 0, 32'h0, "rst_hold_a0");
        expect_rd(1, 0, 32'h0, "rst_hold_b0");
        expect_ovfl(1, 32'h0, "rst_hold_ovfl_b");
        @(negedge clk);
        evt_a = '0;
        evt_b = '0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        expect_rd(0, 0, 32'h0, "post_rst_a0");
        expect_rd(0, 16, 32'h0, "post_rst_ctrl");

        #5;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spio_hss_multiplexer_ctr_bank.md
Name: spio_hss_multiplexer_ctr_bank

Overview:
- Parametrised event-counter register bank for the HSS multiplexer.
- Generalises the fixed status-counter set to NUM_CTRS counters of CTR_BITS width.
- Adds wrap/saturate mode, sticky overflow flags, clear-on-read, freeze, and counter preload by write.
- Sits beside the multiplexer register bank on the same register access interface. Frame assembler/transmitter/disassembler/dispatcher status pulses drive ctr_evt.

Parameters:
- NUM_CTRS, 16, number of event counters; range 1..REGD_BITS.
- CTR_BITS, 32, counter width; range 1..REGD_BITS.
- REGD_BITS, 32, register data width.
- REGA_BITS, 5, register address width; must satisfy 2^REGA_BITS >= NUM_CTRS+2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- ctr_evt  input  NUM_CTRS  one-cycle event pulses; bit i increments counter i; a level held high counts once per cycle
- reg_write  input  1  register write strobe
- reg_read  input  1  register read strobe; qualifies clear-on-read only
- reg_addr  input  REGA_BITS  register address
- reg_write_data  input  REGD_BITS  write data
- reg_read_data  output  REGD_BITS  combinational read data for reg_addr
- ctr_ovfl  output  NUM_CTRS  sticky overflow flags, registered

Behaviour:
- Clocking and reset: one clock domain, clk. rst is asynchronous, active-high, and clears all counters, ctr_ovfl and CTRL to 0.
- Address map:
  - addr 0..NUM_CTRS-1: counter i, zero-extended to REGD_BITS.
  - addr NUM_CTRS: CTRL register, R/W. bit0 SAT (1 = saturate, 0 = wrap). bit1 COR (clear-on-read). bit2 FRZ (freeze). Other bits read 0 and ignore writes.
  - addr NUM_CTRS+1: OVFL register, reads ctr_ovfl zero-extended; write-1-to-clear per bit.
  - Any other address reads all ones; writes to it are ignored.
- Read path: reg_read_data is purely combinational from reg_addr and current register state, with zero latency. It shows the pre-clear value in the cycle that reg_read is asserted.
- Counting, per counter per cycle, in priority order:
  1. reg_write to counter i: load reg_write_data[CTR_BITS-1:0]. The event that cycle is dropped. ovfl[i] is unchanged.
  2. Otherwise, COR=1 and reg_read to counter i: the counter becomes 1 if ctr_evt[i] and FRZ=0, else 0. No event is lost across a clearing read.
  3. Otherwise, ctr_evt[i]=1 and FRZ=0:
     - Counter below max (2^CTR_BITS-1): increment by 1.
     - At max with SAT=0: wrap to 0 and set ovfl[i].
     - At max with SAT=1: hold at max and set ovfl[i].
  4. Otherwise: hold.
- FRZ=1:
  - All events are dropped and the counters hold, so readout is coherent.
  - Loads and clear-on-read still operate.
  - Overflow flags cannot be set.
- Overflow flags:
  - ctr_ovfl[i] is set on the overflow condition and is sticky until cleared.
  - Cleared by a write to OVFL with bit i = 1.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins (flag stays 1).
  - ctr_ovfl updates on the same clock edge as the counter.
- Clear-on-read scope: COR clears only counter addresses. Reads of CTRL and OVFL have no side effect.
- Simultaneous access: reg_write and reg_read together at the same counter address means the write wins (priority 1).
- Mode changes: a change to SAT/COR/FRZ takes effect from the cycle after the CTRL write. Counters are not modified by a mode change.
- Reset mid-operation: everything returns immediately to 0 asynchronously. Events asserted during rst are not counted.
- Latency: an event in cycle n is visible on reg_read_data from cycle n+1.

Test Plan:
- Reset state: assert rst, release, read addr 0..NUM_CTRS+1 -> all 0. Read addr NUM_CTRS+2 -> 0xFFFFFFFF.
- Basic counting: pulse ctr_evt[3] for 5 cycles, then hold ctr_evt[0] high 10 cycles -> counter3 = 5, counter0 = 10, others 0, ctr_ovfl = 0.
- Wrap vs saturate:
  - CTR_BITS=4, SAT=0: preload counter1 = 15, one event -> counter1 = 0, ctr_ovfl[1] = 1.
  - Repeat with SAT=1 -> counter1 = 15, ctr_ovfl[1] = 1.
  - Write OVFL = 0x2 -> ctr_ovfl = 0.
- Clear-on-read race: COR=1, counter2 = 7. Assert reg_read at addr 2 with ctr_evt[2]=1 in the same cycle -> read data 7, counter2 = 1 next cycle. Repeat without the event -> counter2 = 0.
- Freeze and priority:
  - FRZ=1, pulse ctr_evt[5] 4 times -> counter5 unchanged.
  - Write counter5 = 0x1234 with ctr_evt[5]=1 in the same cycle -> 0x1234.
  - Clear FRZ, one event -> 0x1235.
- Async reset mid-count: hold ctr_evt all-ones, assert rst between clock edges -> counters and ctr_ovfl go 0 without a clock edge, and stay 0 while rst is high.
